fft_frame_sequencer: RTL and testbench

FFT_FRAME_SEQUENCER -- requirements
Module: fft_frame_sequencer

---
 rtl/fft_frame_sequencer_if.sv | 29 ++
 rtl/fft_frame_sequencer.sv | 173 +++++++++++++++++
 tb/tb_fft_frame_sequencer.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/fft_frame_sequencer_if.sv
// Bus-slave and FFT output-stream signal bundle for fft_frame_sequencer.
// The master side drives the bus strobes and the stream; the slave side returns read_data and source_ready.
interface fft_frame_sequencer_if #(
   parameter int DATA_SIZE = 28
);
   logic                 chipselect;
   logic                 read;
   logic                 write;
   logic [1:0]           address;
   logic [31:0]          write_data;
   logic [31:0]          read_data;
   logic                 source_valid;
   logic [DATA_SIZE-1:0] source_data;
   logic                 source_sop;
   logic                 source_eop;
   logic                 source_ready;

   modport master (
      output chipselect, read, write, address, write_data,
      output source_valid, source_data, source_sop, source_eop,
      input  read_data, source_ready
   );

   modport slave (
      input  chipselect, read, write, address, write_data,
      input  source_valid, source_data, source_sop, source_eop,
      output read_data, source_ready
   );
endinterface

// File: rtl/fft_frame_sequencer.sv
// Captures one FFT frame from the stream into a buffer, then lets the host drain it word by word.
// Optional dropped-frame counter enabled by defining FFT_SEQ_DROP_CNT_EN.
module fft_frame_sequencer #(
   parameter int DATA_SIZE = 28,
   parameter int FRAME_LEN = 256
) (
   input logic                  clk,
   input logic                  reset,
   fft_frame_sequencer_if.slave bus
);
   localparam int AW = $clog2(FRAME_LEN);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_SOP = 2'd1,
      CAPTURE  = 2'd2,
      DRAIN    = 2'd3
   } state_t;

   state_t         state_reg;
   logic [CW-1:0]  count_reg;
   logic [CW-1:0]  length_reg;
   logic [CW-1:0]  rd_ptr_reg;
   logic           resync_reg;
   logic           cont_reg;
   logic           source_ready_reg;
   logic [15:0]    frame_cnt_reg;
   logic [31:0]    read_data_reg;

   logic [DATA_SIZE-1:0] frame_mem [FRAME_LEN];

   logic          accept;
   logic          bus_rd;
   logic          ctrl_wr;
   logic          arm;
   logic          abort;
   logic          data_rd;
   logic          wr_en;
   logic [AW-1:0] wr_idx;
   logic [CW-1:0] count_inc;
   logic [CW-1:0] new_count;
   logic          capture_done;
   logic          last_rd;
   logic [31:0]   status_word;
   logic [31:0]   frames_word;
   logic          unused_wdata;

   // A simultaneous read and write performs only the write.
   assign accept       = bus.source_valid && source_ready_reg;
   assign bus_rd       = bus.chipselect && bus.read && !bus.write;
   assign ctrl_wr      = bus.chipselect && bus.write && (bus.address == 2'd2);
   assign abort        = ctrl_wr && bus.write_data[2];
   assign arm          = ctrl_wr && bus.write_data[0];
   assign data_rd      = bus_rd && (bus.address == 2'd0);
   assign unused_wdata = ^bus.write_data[31:3];

   assign count_inc    = count_reg + CW'(1);
   assign new_count    = bus.source_sop ? CW'(1) : count_inc;
   assign capture_done = bus.source_eop || (new_count == CW'(FRAME_LEN));
   assign last_rd      = (rd_ptr_reg == length_reg - CW'(1));

   assign wr_en  = accept && ((state_reg == CAPTURE) ||
                              ((state_reg == WAIT_SOP) && bus.source_sop));
   assign wr_idx = bus.source_sop ? '0 : count_reg[AW-1:0];

   assign status_word = {5'd0, 11'(rd_ptr_reg), 11'(length_reg), 1'b0,
                         cont_reg, resync_reg, state_reg};

`ifdef FFT_SEQ_DROP_CNT_EN
   logic [15:0] drop_cnt_reg;

   // Counts sop beats that arrive while the host still owns the buffer.
   always_ff @(posedge clk) begin
      if (!reset || abort) begin
         drop_cnt_reg <= 16'd0;
      end else if ((state_reg == DRAIN) && bus.source_valid && bus.source_sop &&
                   (drop_cnt_reg != 16'hFFFF)) begin
         drop_cnt_reg <= drop_cnt_reg + 16'd1;
      end
   end

   assign frames_word = {drop_cnt_reg, frame_cnt_reg};
`else
   assign frames_word = {16'd0, frame_cnt_reg};
`endif

   always_ff @(posedge clk) begin
      if (wr_en) begin
         frame_mem[wr_idx] <= bus.source_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg        <= IDLE;
         count_reg        <= '0;
         length_reg       <= '0;
         rd_ptr_reg       <= '0;
         resync_reg       <= 1'b0;
         cont_reg         <= 1'b0;
         source_ready_reg <= 1'b0;
         frame_cnt_reg    <= 16'd0;
         read_data_reg    <= 32'd0;
      end else begin
         if (bus_rd) begin
            case (bus.address)
               2'd0:    read_data_reg <= (state_reg == DRAIN) ?
                                         32'(frame_mem[rd_ptr_reg[AW-1:0]]) : 32'd0;
               2'd1:    read_data_reg <= status_word;
               2'd3:    read_data_reg <= frames_word;
               default: read_data_reg <= 32'd0;
            endcase
         end

         if (ctrl_wr) begin
            cont_reg <= abort ? bus.write_data[1] : (cont_reg | bus.write_data[1]);
         end

         if (abort) begin
            state_reg        <= IDLE;
            source_ready_reg <= 1'b0;
            resync_reg       <= 1'b0;
            rd_ptr_reg       <= '0;
            count_reg        <= '0;
         end else begin
            case (state_reg)
               IDLE: begin
                  if (arm) begin
                     state_reg        <= WAIT_SOP;
                     source_ready_reg <= 1'b1;
                  end
               end
               WAIT_SOP: begin
                  if (accept && bus.source_sop) begin
                     count_reg <= CW'(1);
                     state_reg <= CAPTURE;
                  end
               end
               CAPTURE: begin
                  if (accept) begin
                     if (bus.source_sop) begin
                        resync_reg <= 1'b1;
                     end
                     if (capture_done) begin
                        state_reg        <= DRAIN;
                        source_ready_reg <= 1'b0;
                        length_reg       <= new_count;
                        count_reg        <= '0;
                        rd_ptr_reg       <= '0;
                        frame_cnt_reg    <= frame_cnt_reg + 16'd1;
                     end else begin
                        count_reg <= new_count;
                     end
                  end
               end
               DRAIN: begin
                  if (data_rd) begin
                     rd_ptr_reg <= rd_ptr_reg + CW'(1);
                     if (last_rd) begin
                        state_reg        <= cont_reg ? WAIT_SOP : IDLE;
                        source_ready_reg <= cont_reg;
                     end
                  end
               end
            endcase
         end
      end
   end

   assign bus.read_data    = read_data_reg;
   assign bus.source_ready = source_ready_reg;
endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Directed bench for fft_frame_sequencer (FRAME_LEN=8, DATA_SIZE=28) with a read-data scoreboard.
// Expected FRAMES[31:16] follows FFT_SEQ_DROP_CNT_EN.
module tb_fft_frame_sequencer;
   localparam int DS = 28;
   localparam int FL = 8;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   logic rd_seen = 1'b0;
   logic [31:0] exp_q [$];
   string       name_q [$];

   always #10 clk = ~clk;

   fft_frame_sequencer_if #(.DATA_SIZE(DS)) bus ();

   fft_frame_sequencer #(
      .DATA_SIZE (DS),
      .FRAME_LEN (FL)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always @(posedge clk) rd_seen <= bus.chipselect && bus.read && !bus.write && reset;

   // read_data is valid on the negedge following each accepted read
   initial begin : monitor
      logic [31:0] e;
      string       nm;
      forever begin
         @(negedge clk);
         if (rd_seen) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_read: read_data=%h with no pending expectation", bus.read_data);
            end else begin
               e  = exp_q.pop_front();
               nm = name_q.pop_front();
               if (bus.read_data !== e) begin
                  errors++;
                  $display("FAIL %s: read_data=%h expected %h", nm, bus.read_data, e);
               end else begin
                  $display("ok   %s: read_data=%h", nm, bus.read_data);
               end
            end
         end
      end
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   task automatic check_now(input string nm, input logic [31:0] act, input logic [31:0] e);
      checks++;
      if (act !== e) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, e);
      end else begin
         $display("ok   %s: %h", nm, act);
      end
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      bus.chipselect = 1'b1; bus.write = 1'b1; bus.address = a; bus.write_data = d;
      @(negedge clk);
      bus.chipselect = 1'b0; bus.write = 1'b0;
      $display("write addr=%0d data=%h", a, d);
   endtask

   task automatic bus_read(input logic [1:0] a, input logic [31:0] e, input string nm);
      exp_q.push_back(e);
      name_q.push_back(nm);
      bus.chipselect = 1'b1; bus.read = 1'b1; bus.address = a;
      @(negedge clk);
      bus.chipselect = 1'b0; bus.read = 1'b0;
   endtask

   task automatic beat(input logic [DS-1:0] d, input logic sop, input logic eop);
      bus.source_valid = 1'b1; bus.source_data = d; bus.source_sop = sop; bus.source_eop = eop;
      @(negedge clk);
      bus.source_valid = 1'b0; bus.source_sop = 1'b0; bus.source_eop = 1'b0;
      $display("beat data=%h sop=%0b eop=%0b", d, sop, eop);
   endtask

   task automatic full_frame(input logic [DS-1:0] base);
      for (int i = 0; i < FL; i++) beat(base + DS'(i), i == 0, 1'b0);
   endtask

   task automatic drain(input logic [31:0] base, input int n);
      for (int i = 0; i < n; i++) bus_read(2'd0, base + 32'(i), "data");
   endtask

   task automatic do_reset();
      reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin : stim
      logic [31:0] frames_exp;
      bus.chipselect = 1'b0; bus.read = 1'b0; bus.write = 1'b0;
      bus.address = 2'd0; bus.write_data = 32'd0;
      bus.source_valid = 1'b0; bus.source_data = '0;
      bus.source_sop = 1'b0; bus.source_eop = 1'b0;
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check_now("reset_read_data", bus.read_data, 32'd0);
      check_now("reset_ready", 32'(bus.source_ready), 32'd0);
      reset = 1'b1;
      @(negedge clk);
      check_now("post_reset_ready", 32'(bus.source_ready), 32'd0);
      bus_read(2'd1, 32'h0, "reset_status");
      bus_read(2'd3, 32'h0, "reset_frames");

      // full-length frame
      bus_write(2'd2, 32'h1);
      bus_read(2'd1, 32'h1, "armed_status");
      check_now("armed_ready", 32'(bus.source_ready), 32'd1);
      full_frame(DS'('h10));
      check_now("drain_ready", 32'(bus.source_ready), 32'd0);
      bus_read(2'd1, 32'h103, "full_drain_status");
      drain(32'h10, 8);
      bus_read(2'd1, 32'h80100, "full_idle_status");
      bus_read(2'd3, 32'h1, "frames_1");
      bus_read(2'd0, 32'h0, "data_in_idle");
      bus_write(2'd1, 32'hFFFF_FFFF);
      bus_write(2'd3, 32'hFFFF_FFFF);
      bus_write(2'd0, 32'hFFFF_FFFF);
      bus_read(2'd1, 32'h80100, "ignored_writes_status");
      bus_read(2'd3, 32'h1, "ignored_writes_frames");

      // pre-sop discard then short eop frame
      bus_write(2'd2, 32'h1);
      beat(DS'('h1), 1'b0, 1'b0);
      beat(DS'('h2), 1'b0, 1'b0);
      beat(DS'('h3), 1'b0, 1'b0);
      bus_read(2'd1, 32'h80101, "discard_status");
      beat(DS'('hA), 1'b1, 1'b0);
      beat(DS'('hB), 1'b0, 1'b0);
      beat(DS'('hC), 1'b0, 1'b1);
      bus_read(2'd1, 32'h63, "short_drain_status");
      drain(32'hA, 3);
      bus_read(2'd1, 32'h30060, "short_idle_status");
      bus_read(2'd3, 32'h2, "frames_2");

      // continuous mode
      do_reset();
      bus_write(2'd2, 32'h3);
      bus_read(2'd1, 32'h9, "cont_status");
      full_frame(DS'('h20));
      bus_read(2'd1, 32'h10B, "cont_drain_status");
      drain(32'h20, 8);
      bus_read(2'd1, 32'h80109, "cont_rearm1_status");
      check_now("cont_ready", 32'(bus.source_ready), 32'd1);
      full_frame(DS'('h30));
      drain(32'h30, 8);
      bus_read(2'd1, 32'h80109, "cont_rearm2_status");
      bus_read(2'd3, 32'h2, "cont_frames");

      // mid-capture resync
      for (int i = 0; i < 4; i++) beat(DS'('h40 + i), i == 0, 1'b0);
      full_frame(DS'('h50));
      bus_read(2'd1, 32'h10F, "resync_status");
      drain(32'h50, 8);
      bus_read(2'd1, 32'h8010D, "resync_after_status");
      bus_read(2'd3, 32'h3, "resync_frames");

      // sop pulses while draining
      beat(DS'('h60), 1'b1, 1'b0);
      beat(DS'('h61), 1'b0, 1'b0);
      beat(DS'('h62), 1'b0, 1'b1);
      bus_read(2'd1, 32'h6F, "drop_drain_status");
      for (int i = 0; i < 3; i++) begin
         bus.source_valid = 1'b1; bus.source_sop = 1'b1; bus.source_data = DS'('h90 + i);
         check_now("drop_ready", 32'(bus.source_ready), 32'd0);
         @(negedge clk);
         bus.source_valid = 1'b0; bus.source_sop = 1'b0;
         check_now("drop_ready_after", 32'(bus.source_ready), 32'd0);
         @(negedge clk);
      end
`ifdef FFT_SEQ_DROP_CNT_EN
      frames_exp = 32'h0003_0004;
`else
      frames_exp = 32'h0000_0004;
`endif
      bus_read(2'd3, frames_exp, "drop_frames");
      drain(32'h60, 3);
      bus_read(2'd1, 32'h3006D, "drop_after_status");

      // abort in capture, reset in drain
      beat(DS'('h70), 1'b1, 1'b0);
      beat(DS'('h71), 1'b0, 1'b0);
      bus_read(2'd1, 32'h3006E, "capture_status");
      bus_write(2'd2, 32'h4);
      check_now("abort_ready", 32'(bus.source_ready), 32'd0);
      bus_read(2'd1, 32'h60, "abort_status");
      bus_read(2'd3, 32'h4, "abort_frames");
      bus_write(2'd2, 32'h1);
      full_frame(DS'('h80));
      bus_read(2'd1, 32'h103, "pre_reset_drain_status");
      bus_read(2'd0, 32'h80, "pre_reset_data");
      bus_read(2'd1, 32'h10103, "partial_drain_status");
      do_reset();
      check_now("mid_drain_reset_read_data", bus.read_data, 32'd0);
      check_now("mid_drain_reset_ready", 32'(bus.source_ready), 32'd0);
      bus_read(2'd1, 32'h0, "after_reset_status");
      bus_read(2'd3, 32'h0, "after_reset_frames");
      bus_read(2'd0, 32'h0, "after_reset_data");

      repeat (3) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL pending_reads: %0d outstanding expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
